// File: rtl/softusb_timer_multi_if.sv
// +------------------------------------------------------------------+
// | softusb_timer_multi_if : navre I/O bus plus per-channel irq pair  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface softusb_timer_multi_if #(
  parameter int nchan = 2
);
  logic             io_re;
  logic             io_we;
  logic [5:0]       io_a;
  logic [7:0]       io_di;
  logic [7:0]       io_do;
  logic [nchan-1:0] irq;
  logic [nchan-1:0] irq_ack;

  modport master (
    output io_re, io_we, io_a, io_di, irq_ack,
    input  io_do, irq
  );

  modport slave (
    input  io_re, io_we, io_a, io_di, irq_ack,
    output io_do, irq
  );
endinterface

`default_nettype wire

// File: rtl/softusb_timer_multi.sv
// +------------------------------------------------------------------+
// | softusb_timer_multi : up to 4 prescaled down-counters on navre I/O|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module softusb_timer_multi #(
  parameter logic [5:0] io_base   = 6'h20,
  parameter int         nchan     = 2,
  parameter int         cnt_width = 16
) (
  input  logic                  usb_clk,
  input  logic                  usb_rst,
  softusb_timer_multi_if.slave  bus
);

  localparam int NB = cnt_width / 8;

  logic [5:0] w_off;
  logic       w_hit;
  logic [1:0] w_chan;
  logic [2:0] w_reg;
  logic [1:0] w_byte;

  assign w_off  = bus.io_a - io_base;
  assign w_hit  = (bus.io_a >= io_base) && ({1'b0, w_off} < 7'(8 * nchan));
  assign w_chan = w_off[4:3];
  assign w_reg  = w_off[2:0];
  assign w_byte = w_off[1:0];

  logic [7:0]       w_rd [nchan];
  logic [nchan-1:0] w_irq;

  for (genvar gi = 0; gi < nchan; gi++) begin : g_chan
    localparam logic [1:0] CH = 2'(gi);

    logic                 en_q, en_d, per_q, per_d, irqen_q, irqen_d;
    logic                 expired_q, expired_d;
    logic [7:0]           presc_q, presc_d, pcnt_q, pcnt_d;
    logic [cnt_width-1:0] count_q, count_d, reload_q, reload_d;
    logic [cnt_width-1:0] shadow_q, shadow_d, latch_q, latch_d;

    logic                 w_sel, w_wr, w_tick, w_load, w_expire;
    logic                 w_rl_wr, w_commit;
    logic [cnt_width-1:0] w_merge, w_src;
    logic [7:0]           w_rdata;

    assign w_sel    = w_hit && (w_chan == CH);
    assign w_wr     = w_sel && bus.io_we;
    assign w_tick   = en_q && (pcnt_q == presc_q);
    assign w_load   = w_wr && (w_reg == 3'd0) && bus.io_di[3];
    assign w_expire = w_tick && !w_load && (count_q == '0);
    assign w_rl_wr  = w_wr && w_reg[2] && (int'(w_byte) < NB);
    assign w_commit = w_rl_wr && (int'(w_byte) == NB - 1);

    // Shadow with the addressed byte replaced; the top byte commits the whole word.
    always_comb begin
      w_merge = shadow_q;
      for (int k = 0; k < NB; k++) begin
        if (w_byte == 2'(k)) begin
          w_merge[8*k +: 8] = bus.io_di;
        end
      end
    end

    always_comb begin
      en_d      = en_q;
      per_d     = per_q;
      irqen_d   = irqen_q;
      presc_d   = presc_q;
      pcnt_d    = pcnt_q;
      count_d   = count_q;
      reload_d  = reload_q;
      shadow_d  = shadow_q;
      latch_d   = latch_q;
      expired_d = expired_q;

      if (en_q) begin
        pcnt_d = w_tick ? 8'd0 : pcnt_q + 8'd1;
      end
      if (w_tick) begin
        if (count_q != '0) begin
          count_d = count_q - {{(cnt_width-1){1'b0}}, 1'b1};
        end else if (per_q) begin
          count_d = reload_q;
        end else begin
          en_d = 1'b0;
        end
      end
      if (w_wr && (w_reg == 3'd0)) begin
        {irqen_d, per_d, en_d} = bus.io_di[2:0];
      end
      if (w_load) begin
        count_d = reload_q;
        pcnt_d  = 8'd0;
      end
      if (w_wr && (w_reg == 3'd2)) begin
        presc_d = bus.io_di;
      end
      if (w_rl_wr) begin
        shadow_d = w_merge;
      end
      if (w_commit) begin
        reload_d = w_merge;
      end
      if (w_sel && bus.io_re && (w_reg == 3'd4)) begin
        latch_d = count_q;
      end
      if (bus.irq_ack[gi] || (w_wr && (w_reg == 3'd1) && bus.io_di[0])) begin
        expired_d = 1'b0;
      end
      if (w_expire) begin
        expired_d = 1'b1;
      end
    end

    always_ff @(posedge usb_clk) begin
      if (usb_rst) begin
        en_q      <= 1'b0;
        per_q     <= 1'b0;
        irqen_q   <= 1'b0;
        presc_q   <= 8'd0;
        pcnt_q    <= 8'd0;
        count_q   <= '0;
        reload_q  <= '0;
        shadow_q  <= '0;
        latch_q   <= '0;
        expired_q <= 1'b0;
      end else begin
        en_q      <= en_d;
        per_q     <= per_d;
        irqen_q   <= irqen_d;
        presc_q   <= presc_d;
        pcnt_q    <= pcnt_d;
        count_q   <= count_d;
        reload_q  <= reload_d;
        shadow_q  <= shadow_d;
        latch_q   <= latch_d;
        expired_q <= expired_d;
      end
    end

    // Byte 0 of COUNT is live; higher bytes come from the copy latched on the byte-0 read.
    assign w_src = (w_byte == 2'd0) ? count_q : latch_q;

    always_comb begin
      w_rdata = 8'h00;
      if (w_reg[2]) begin
        for (int k = 0; k < NB; k++) begin
          if (w_byte == 2'(k)) begin
            w_rdata = w_src[8*k +: 8];
          end
        end
      end else begin
        case (w_reg)
          3'd0:    w_rdata = {5'd0, irqen_q, per_q, en_q};
          3'd1:    w_rdata = {7'd0, expired_q};
          3'd2:    w_rdata = presc_q;
          default: w_rdata = 8'h00;
        endcase
      end
    end

    assign w_rd[gi]  = w_rdata;
    assign w_irq[gi] = expired_q & irqen_q;
  end

  logic [7:0] io_do_q, io_do_d;

  always_comb begin
    io_do_d = 8'h00;
    for (int c = 0; c < nchan; c++) begin
      if (w_hit && (w_chan == 2'(c))) begin
        io_do_d = w_rd[c];
      end
    end
  end

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      io_do_q <= 8'h00;
    end else begin
      io_do_q <= io_do_d;
    end
  end

  assign bus.io_do = io_do_q;
  assign bus.irq   = w_irq;

endmodule

`default_nettype wire
